// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Latency: none (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    // RV32I load/store width encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } lsu_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_ILLEGAL  = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fault_cause_t;

    // Data memory is word addressed on the bus; byte lanes come from mem_be.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Latency: none (wires only).
// Backpressure: master holds req/we/addr/be/wdata until gnt; read data returns with rvalid.
//
// Signals: mem_req/mem_we/mem_addr/mem_be/mem_wdata  master -> slave
//          mem_gnt/mem_rvalid/mem_rdata                slave  -> master
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / lane replication, load shift-to-LSB, access checks.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_funct3, i_addr_lo, i_wdata, i_mem_rdata in;
//        o_mem_be, o_mem_wdata, o_rdata_aligned, o_misaligned, o_illegal out.
// o_illegal flags only the undefined encodings; store-with-unsigned is checked by the caller,
// which knows the access direction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    output logic [31:0] o_rdata_aligned,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic [31:0] w_byte_shift;

    assign w_byte_shift = i_mem_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_mem_be        = 4'b0000;
        o_mem_wdata     = 32'h0;
        o_rdata_aligned = 32'h0;
        o_misaligned    = 1'b0;
        o_illegal       = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_mem_be        = 4'b0001 << i_addr_lo;
                o_mem_wdata     = {4{i_wdata[7:0]}};
                o_rdata_aligned = {24'h0, w_byte_shift[7:0]};
            end
            F3_H, F3_HU: begin
                o_mem_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_mem_wdata     = {2{i_wdata[15:0]}};
                o_rdata_aligned = {16'h0, (i_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0])};
                o_misaligned    = i_addr_lo[0];
            end
            F3_W: begin
                o_mem_be        = 4'b1111;
                o_mem_wdata     = i_wdata;
                o_rdata_aligned = i_mem_rdata;
                o_misaligned    = |i_addr_lo;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: issues one data-memory access per request and aligns load data.
// Latency: load 3 stall cycles (done on 4th), store 2, faulting access 1; plus memory wait.
// Backpressure: stall held while a request is in flight; bus request held until mem_gnt.
//
// Ports: i_clk, i_reset (sync, active high); pipeline side i_req_valid/i_req_we/i_Funct3/
//        i_addr/i_wdata in, o_stall/o_done/o_rdata_aligned/o_Funct3_out/o_fault/o_fault_cause out;
//        data memory through the mem interface (master modport).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req_valid,
    input  logic                      i_req_we,
    input  logic [2:0]                i_Funct3,
    input  logic [31:0]               i_addr,
    input  logic [31:0]               i_wdata,
    output logic                      o_stall,
    output logic                      o_done,
    output logic [31:0]               o_rdata_aligned,
    output logic [2:0]                o_Funct3_out,
    output logic                      o_fault,
    output logic [1:0]                o_fault_cause,
    load_store_unit_if.master         mem
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t   r_state;
    lsu_state_t   w_next_state;
    fault_cause_t r_fault_cause;
    fault_cause_t w_next_cause;

    logic          r_we;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata_aligned;
    logic [TW-1:0] r_timer;

    logic          w_in_idle;
    logic          w_in_issue;
    logic [2:0]    w_sel_funct3;
    logic [1:0]    w_sel_addr_lo;
    logic [31:0]   w_sel_wdata;
    logic [3:0]    w_be;
    logic [31:0]   w_lane_wdata;
    logic [31:0]   w_load_aligned;
    logic          w_misaligned;
    logic          w_illegal_enc;
    logic          w_illegal;
    logic          w_timeout_hit;

    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_in_issue = (r_state == ST_ISSUE);

    // In IDLE the checks must see the incoming request; afterwards the captured
    // copy drives the bus and the load alignment.
    assign w_sel_funct3  = w_in_idle ? i_Funct3    : r_funct3;
    assign w_sel_addr_lo = w_in_idle ? i_addr[1:0] : r_addr[1:0];
    assign w_sel_wdata   = w_in_idle ? i_wdata     : r_wdata;

    lsu_align u_align (
        .i_funct3        (w_sel_funct3),
        .i_addr_lo       (w_sel_addr_lo),
        .i_wdata         (w_sel_wdata),
        .i_mem_rdata     (mem.mem_rdata),
        .o_mem_be        (w_be),
        .o_mem_wdata     (w_lane_wdata),
        .o_rdata_aligned (w_load_aligned),
        .o_misaligned    (w_misaligned),
        .o_illegal       (w_illegal_enc)
    );

    // Unsigned widths have no store form.
    assign w_illegal = w_illegal_enc |
                       (i_req_we & ((i_Funct3 == F3_BU) | (i_Funct3 == F3_HU)));

    // Counter holds the number of completed ISSUE/WAIT cycles, so the
    // TIMEOUT_CYCLES-th cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign w_timeout_hit = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_fault_cause;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (w_illegal) begin
                        w_next_state = ST_ERR;
                        w_next_cause = FC_ILLEGAL;
                    end else if (w_misaligned) begin
                        w_next_state = ST_ERR;
                        w_next_cause = FC_MISALIGN;
                    end else begin
                        w_next_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A grant in the final counted cycle still wins over the timeout.
                if (mem.mem_gnt) begin
                    w_next_state = r_we ? ST_DONE : ST_WAIT;
                end else if (w_timeout_hit) begin
                    w_next_state = ST_ERR;
                    w_next_cause = FC_TIMEOUT;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    w_next_state = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_next_state = ST_ERR;
                    w_next_cause = FC_TIMEOUT;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            ST_ERR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_fault_cause   <= FC_NONE;
            r_we            <= 1'b0;
            r_funct3        <= 3'b000;
            r_addr          <= 32'h0;
            r_wdata         <= 32'h0;
            r_rdata_aligned <= 32'h0;
            r_timer         <= '0;
        end else begin
            r_state       <= w_next_state;
            r_fault_cause <= w_next_cause;

            if (w_in_idle && i_req_valid) begin
                r_we     <= i_req_we;
                r_funct3 <= i_Funct3;
                r_addr   <= i_addr;
                r_wdata  <= i_wdata;
            end

            if (w_in_idle) begin
                r_timer <= '0;
            end else if (w_in_issue || (r_state == ST_WAIT)) begin
                r_timer <= r_timer + TW'(1);
            end

            if ((r_state == ST_WAIT) && mem.mem_rvalid) begin
                r_rdata_aligned <= w_load_aligned;
            end
        end
    end

    // Bus outputs are only meaningful while requesting; zero them otherwise so
    // memory never sees a stale strobe pattern.
    assign mem.mem_req   = w_in_issue;
    assign mem.mem_we    = w_in_issue & r_we;
    assign mem.mem_addr  = w_in_issue ? word_addr(r_addr) : 32'h0;
    assign mem.mem_be    = w_in_issue ? w_be : 4'b0000;
    assign mem.mem_wdata = w_in_issue ? w_lane_wdata : 32'h0;

    assign o_stall         = i_req_valid & (r_state != ST_DONE) & (r_state != ST_ERR);
    assign o_done          = (r_state == ST_DONE) | (r_state == ST_ERR);
    assign o_fault         = (r_state == ST_ERR);
    assign o_fault_cause   = (r_state == ST_ERR) ? r_fault_cause : FC_NONE;
    assign o_rdata_aligned = r_rdata_aligned;
    assign o_Funct3_out    = r_funct3;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and reset abandonment.
// Latency: n/a.
// Backpressure: memory responses are driven directly by the step sequence.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata_aligned;
    logic [2:0]  funct3_out;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cycles;

    load_store_unit_if u_if ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_req_valid     (req_valid),
        .i_req_we        (req_we),
        .i_Funct3        (funct3),
        .i_addr          (addr),
        .i_wdata         (wdata),
        .o_stall         (stall),
        .o_done          (done),
        .o_rdata_aligned (rdata_aligned),
        .o_Funct3_out    (funct3_out),
        .o_fault         (fault),
        .o_fault_cause   (fault_cause),
        .mem             (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = d;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        u_if.mem_gnt    = 1'b0;
        u_if.mem_rvalid = 1'b0;
        u_if.mem_rdata  = 32'h0;

        // ---------------- reset state ----------------
        step();
        step();
        settle();
        chk("rst_stall",  32'(stall), 32'h0);
        chk("rst_done",   32'(done), 32'h0);
        chk("rst_rdata",  rdata_aligned, 32'h0);
        chk("rst_f3out",  32'(funct3_out), 32'h0);
        chk("rst_cause",  32'(fault_cause), 32'h0);
        chk("rst_req",    32'(u_if.mem_req), 32'h0);
        chk("rst_be",     32'(u_if.mem_be), 32'h0);
        reset = 1'b0;
        step();

        // ---------------- LB 0x1003, immediate gnt/rvalid ----------------
        drive_req(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        settle();
        chk("lb_c1_stall", 32'(stall), 32'h1);
        chk("lb_c1_req",   32'(u_if.mem_req), 32'h0);
        step();
        u_if.mem_gnt = 1'b1;
        settle();
        chk("lb_c2_stall", 32'(stall), 32'h1);
        chk("lb_c2_req",   32'(u_if.mem_req), 32'h1);
        chk("lb_c2_addr",  u_if.mem_addr, 32'h0000_1000);
        chk("lb_c2_be",    32'(u_if.mem_be), 32'h8);
        chk("lb_c2_we",    32'(u_if.mem_we), 32'h0);
        chk("lb_c2_f3out", 32'(funct3_out), 32'h0);
        step();
        u_if.mem_gnt    = 1'b0;
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'h80AA_BBCC;
        settle();
        chk("lb_c3_stall", 32'(stall), 32'h1);
        chk("lb_c3_req",   32'(u_if.mem_req), 32'h0);
        chk("lb_c3_done",  32'(done), 32'h0);
        step();
        u_if.mem_rvalid = 1'b0;
        settle();
        chk("lb_c4_done",  32'(done), 32'h1);
        chk("lb_c4_stall", 32'(stall), 32'h0);
        chk("lb_c4_fault", 32'(fault), 32'h0);
        chk("lb_rdata",    rdata_aligned, 32'h0000_0080);
        req_valid = 1'b0;
        step();
        settle();
        chk("lb_after_done", 32'(done), 32'h0);

        // ---------------- SH 0x2002, gnt after 2 wait cycles ----------------
        drive_req(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
        settle();
        chk("sh_c1_stall", 32'(stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            u_if.mem_gnt = (i == 2);
            settle();
            chk("sh_issue_req",   32'(u_if.mem_req), 32'h1);
            chk("sh_issue_we",    32'(u_if.mem_we), 32'h1);
            chk("sh_issue_addr",  u_if.mem_addr, 32'h0000_2000);
            chk("sh_issue_be",    32'(u_if.mem_be), 32'hC);
            chk("sh_issue_wdata", u_if.mem_wdata, 32'hABCD_ABCD);
            chk("sh_issue_stall", 32'(stall), 32'h1);
        end
        step();
        u_if.mem_gnt = 1'b0;
        settle();
        chk("sh_done",       32'(done), 32'h1);
        chk("sh_done_fault", 32'(fault), 32'h0);
        chk("sh_done_req",   32'(u_if.mem_req), 32'h0);
        chk("sh_done_stall", 32'(stall), 32'h0);
        chk("sh_rdata_kept", rdata_aligned, 32'h0000_0080);
        req_valid = 1'b0;
        step();

        // ---------------- LW 0x3001: misaligned ----------------
        drive_req(1'b0, 3'b010, 32'h0000_3001, 32'h0);
        settle();
        chk("lw_mis_c1_stall", 32'(stall), 32'h1);
        chk("lw_mis_c1_req",   32'(u_if.mem_req), 32'h0);
        step();
        settle();
        chk("lw_mis_done",  32'(done), 32'h1);
        chk("lw_mis_fault", 32'(fault), 32'h1);
        chk("lw_mis_cause", 32'(fault_cause), 32'h1);
        chk("lw_mis_req",   32'(u_if.mem_req), 32'h0);
        chk("lw_mis_stall", 32'(stall), 32'h0);
        chk("lw_mis_rdata", rdata_aligned, 32'h0000_0080);
        chk("lw_mis_f3out", 32'(funct3_out), 32'h2);
        req_valid = 1'b0;
        step();

        // ---------------- store with funct3=100: illegal ----------------
        drive_req(1'b1, 3'b100, 32'h0000_4000, 32'h5555_5555);
        settle();
        chk("sbu_c1_req", 32'(u_if.mem_req), 32'h0);
        step();
        settle();
        chk("sbu_done",  32'(done), 32'h1);
        chk("sbu_fault", 32'(fault), 32'h1);
        chk("sbu_cause", 32'(fault_cause), 32'h2);
        chk("sbu_req",   32'(u_if.mem_req), 32'h0);
        req_valid = 1'b0;
        step();

        // ---------------- LHU 0x4002 ----------------
        drive_req(1'b0, 3'b101, 32'h0000_4002, 32'h0);
        step();
        u_if.mem_gnt = 1'b1;
        settle();
        chk("lhu_be",   32'(u_if.mem_be), 32'hC);
        chk("lhu_addr", u_if.mem_addr, 32'h0000_4000);
        step();
        u_if.mem_gnt    = 1'b0;
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'hFEDC_0000;
        step();
        u_if.mem_rvalid = 1'b0;
        settle();
        chk("lhu_done",  32'(done), 32'h1);
        chk("lhu_cause", 32'(fault_cause), 32'h0);
        chk("lhu_rdata", rdata_aligned, 32'h0000_FEDC);
        chk("lhu_f3out", 32'(funct3_out), 32'h5);
        req_valid = 1'b0;
        step();

        // ---------------- LW with no grant: timeout after 4 cycles ----------------
        drive_req(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            settle();
            if (u_if.mem_req) req_cycles++;
            if (done) break;
        end
        chk("to_done",       32'(done), 32'h1);
        chk("to_req_cycles", 32'(req_cycles), 32'd4);
        chk("to_fault",      32'(fault), 32'h1);
        chk("to_cause",      32'(fault_cause), 32'h3);
        chk("to_req_drop",   32'(u_if.mem_req), 32'h0);
        req_valid = 1'b0;
        step();
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'h1111_2222;
        settle();
        chk("to_stray_done0", 32'(done), 32'h0);
        step();
        settle();
        chk("to_stray_done1", 32'(done), 32'h0);
        chk("to_stray_rdata", rdata_aligned, 32'h0000_FEDC);
        u_if.mem_rvalid = 1'b0;
        step();

        // ---------------- reset while waiting for read data ----------------
        drive_req(1'b0, 3'b010, 32'h0000_6000, 32'h0);
        step();
        u_if.mem_gnt = 1'b1;
        step();
        u_if.mem_gnt = 1'b0;
        settle();
        chk("rw_in_wait_stall", 32'(stall), 32'h1);
        reset     = 1'b1;
        req_valid = 1'b0;
        step();
        settle();
        chk("rw_stall",  32'(stall), 32'h0);
        chk("rw_done",   32'(done), 32'h0);
        chk("rw_fault",  32'(fault), 32'h0);
        chk("rw_cause",  32'(fault_cause), 32'h0);
        chk("rw_rdata",  rdata_aligned, 32'h0);
        chk("rw_f3out",  32'(funct3_out), 32'h0);
        chk("rw_req",    32'(u_if.mem_req), 32'h0);
        chk("rw_we",     32'(u_if.mem_we), 32'h0);
        chk("rw_addr",   u_if.mem_addr, 32'h0);
        chk("rw_be",     32'(u_if.mem_be), 32'h0);
        chk("rw_wdata",  u_if.mem_wdata, 32'h0);
        reset = 1'b0;
        step();
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'hDEAD_BEEF;
        settle();
        chk("rw_late_done0", 32'(done), 32'h0);
        step();
        u_if.mem_rvalid = 1'b0;
        settle();
        chk("rw_late_done1", 32'(done), 32'h0);
        chk("rw_late_rdata", rdata_aligned, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
